opaque_elastic_fifo: RTL and testbench

Data-carrying elastic FIFO that cuts the combinational valid/data path between producer and consumer. It complements the transparent dataless half buffer, which cuts the ready path. Both ins_ready and outs_valid are derived only from registered state, so no combinational path crosses the block in either direction. The handshake pass inserts it on long channels and on channels that close a combinational cycle through valid.

---
 rtl/handshake_pkg.sv | 31 +++
 rtl/elastic_fifo_ctrl.sv | 71 +++++++
 rtl/opaque_elastic_fifo.sv | 63 ++++++
 tb/tb_opaque_elastic_fifo.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// Shared helpers for handshake buffers: width computation and parameter legality.
package handshake_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Pointers index NUM_SLOTS entries; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned num_slots);
        return (clog2(num_slots) > 0) ? clog2(num_slots) : 1;
    endfunction

    // Occupancy must represent 0..num_slots inclusive.
    function automatic int unsigned occ_width(input int unsigned num_slots);
        return clog2(num_slots + 1);
    endfunction

    function automatic bit params_legal(input int unsigned num_slots,
                                        input int unsigned data_width);
        return (num_slots >= 2) && (data_width >= 1);
    endfunction

endpackage

// File: rtl/elastic_fifo_ctrl.sv
// Dataless FIFO control: pointers, occupancy and registered handshake outputs.
// The occ port exists only when OPAQUE_FIFO_COUNT_EN is defined.
module elastic_fifo_ctrl import handshake_pkg::*; #(
    parameter int unsigned NUM_SLOTS = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ins_valid,
    output logic                               ins_ready,
    output logic                               outs_valid,
    input  logic                               outs_ready,
    output logic                               push,
    output logic [ptr_width(NUM_SLOTS)-1:0]    wr_ptr,
`ifdef OPAQUE_FIFO_COUNT_EN
    output logic [occ_width(NUM_SLOTS)-1:0]    occ,
`endif
    output logic [ptr_width(NUM_SLOTS)-1:0]    rd_ptr
);

    localparam int unsigned PtrWidth = ptr_width(NUM_SLOTS);
    localparam int unsigned OccWidth = occ_width(NUM_SLOTS);

    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [OccWidth-1:0] occ_q, occ_d;
    logic                pop;

    // Handshake outputs come only from occ_q, so no path crosses the block.
    always_comb begin
        ins_ready  = (occ_q != OccWidth'(NUM_SLOTS));
        outs_valid = (occ_q != '0);
        push       = ins_valid & ins_ready;
        pop        = outs_valid & outs_ready;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrWidth'(NUM_SLOTS - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrWidth'(NUM_SLOTS - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + OccWidth'(1);
            2'b01:   occ_d = occ_q - OccWidth'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
`ifdef OPAQUE_FIFO_COUNT_EN
    assign occ    = occ_q;
`endif

endmodule

// File: rtl/opaque_elastic_fifo.sv
// Opaque elastic FIFO: registered valid/data and ready, storage plus output mux.
// Defining OPAQUE_FIFO_COUNT_EN adds the registered occupancy port count.
module opaque_elastic_fifo import handshake_pkg::*; #(
    parameter int unsigned DATA_TYPE = 32,
    parameter int unsigned NUM_SLOTS = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_TYPE-1:0]               ins,
    input  logic                               ins_valid,
    output logic                               ins_ready,
    output logic [DATA_TYPE-1:0]               outs,
    output logic                               outs_valid,
`ifdef OPAQUE_FIFO_COUNT_EN
    output logic [occ_width(NUM_SLOTS)-1:0]    count,
`endif
    input  logic                               outs_ready
);

    localparam int unsigned PtrWidth = ptr_width(NUM_SLOTS);

    if (!params_legal(NUM_SLOTS, DATA_TYPE)) begin : g_bad_params
        $error("opaque_elastic_fifo: NUM_SLOTS must be >= 2 and DATA_TYPE >= 1");
    end

    logic                 push;
    logic [PtrWidth-1:0]  wr_ptr;
    logic [PtrWidth-1:0]  rd_ptr;
    logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];
    logic [DATA_TYPE-1:0] mem_d [NUM_SLOTS];

    elastic_fifo_ctrl #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready),
        .push       (push),
        .wr_ptr     (wr_ptr),
`ifdef OPAQUE_FIFO_COUNT_EN
        .occ        (count),
`endif
        .rd_ptr     (rd_ptr)
    );

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr] = ins;
        end
    end

    // Storage is intentionally not reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign outs = mem_q[rd_ptr];

endmodule

// File: tb/tb_opaque_elastic_fifo.sv
// Bench for opaque_elastic_fifo: queue model per instance (depth 4 and depth 3),
// directed scenarios on the depth-4 instance, randomized streaming on the depth-3 one.
module tb_opaque_elastic_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in4, out4, in3, out3;
    logic        in4_valid, in4_ready, out4_valid, out4_ready;
    logic        in3_valid, in3_ready, out3_valid, out3_ready;
`ifdef OPAQUE_FIFO_COUNT_EN
    logic [2:0]  cnt4;
    logic [1:0]  cnt3;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    opaque_elastic_fifo #(.DATA_TYPE(32), .NUM_SLOTS(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .ins        (in4),
        .ins_valid  (in4_valid),
        .ins_ready  (in4_ready),
        .outs       (out4),
        .outs_valid (out4_valid),
`ifdef OPAQUE_FIFO_COUNT_EN
        .count      (cnt4),
`endif
        .outs_ready (out4_ready)
    );

    opaque_elastic_fifo #(.DATA_TYPE(32), .NUM_SLOTS(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .ins        (in3),
        .ins_valid  (in3_valid),
        .ins_ready  (in3_ready),
        .outs       (out3),
        .outs_valid (out3_valid),
`ifdef OPAQUE_FIFO_COUNT_EN
        .count      (cnt3),
`endif
        .outs_ready (out3_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a FIFO is a queue bounded by its depth.
    logic [31:0] q4[$];
    logic [31:0] q3[$];
    bit          started = 1'b0;
    bit          push4, pop4, push3, pop3;
    int          rx3 = 0;

    always @(posedge clk) begin
        if (rst) begin
            q4.delete();
            q3.delete();
            started = 1'b1;
        end else begin
            push4 = in4_valid && (q4.size() < 4);
            pop4  = out4_ready && (q4.size() != 0);
            if (pop4) void'(q4.pop_front());
            if (push4) q4.push_back(in4);
            push3 = in3_valid && (q3.size() < 3);
            pop3  = out3_ready && (q3.size() != 0);
            if (pop3) void'(q3.pop_front());
            if (push3) q3.push_back(in3);
        end
    end

    always @(negedge clk) begin
        if (started && !rst) begin
            chk("m4_valid", 32'(out4_valid), 32'(q4.size() != 0));
            chk("m4_ready", 32'(in4_ready), 32'(q4.size() != 4));
            if (q4.size() != 0) chk("m4_data", out4, q4[0]);
            chk("m3_valid", 32'(out3_valid), 32'(q3.size() != 0));
            chk("m3_ready", 32'(in3_ready), 32'(q3.size() != 3));
            if (q3.size() != 0) chk("m3_data", out3, q3[0]);
`ifdef OPAQUE_FIFO_COUNT_EN
            chk("m4_count", 32'(cnt4), 32'(q4.size()));
            chk("m3_count", 32'(cnt3), 32'(q3.size()));
            chk("m3_count_le3", 32'(cnt3 <= 2'd3), 32'd1);
`endif
            // Sequential source values must emerge in order.
            if (out3_ready && out3_valid) begin
                chk("seq3", out3, 32'(rx3));
                rx3++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  seq3;
        bit  accepted;
        rst = 1'b1;
        in4 = '0; in4_valid = 1'b0; out4_ready = 1'b0;
        in3 = '0; in3_valid = 1'b0; out3_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset then idle
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_valid", 32'(out4_valid), 32'd0);
            chk("idle_ready", 32'(in4_ready), 32'd1);
`ifdef OPAQUE_FIFO_COUNT_EN
            chk("idle_count", 32'(cnt4), 32'd0);
`endif
        end

        // Single word, one-cycle latency
        in4 = 32'hDEADBEEF; in4_valid = 1'b1; out4_ready = 1'b1;
        step();
        in4_valid = 1'b0;
        chk("single_valid", 32'(out4_valid), 32'd1);
        chk("single_data", out4, 32'hDEADBEEF);
        step();
        chk("single_gone", 32'(out4_valid), 32'd0);
        out4_ready = 1'b0;

        // Fill and stall
        for (int w = 1; w <= 4; w++) begin
            in4 = 32'(w); in4_valid = 1'b1;
            step();
        end
        chk("full_ready", 32'(in4_ready), 32'd0);
        chk("full_head", out4, 32'd1);
        in4 = 32'd5;
        step();
        step();
        chk("stall_ready", 32'(in4_ready), 32'd0);
        chk("stall_head", out4, 32'd1);
        out4_ready = 1'b1;
        step();
        chk("reopen_ready", 32'(in4_ready), 32'd1);
        chk("drain_2", out4, 32'd2);
        step();
        in4_valid = 1'b0;
        chk("drain_3", out4, 32'd3);
        step();
        chk("drain_4", out4, 32'd4);
        step();
        chk("drain_5", out4, 32'd5);
        step();
        chk("drain_empty", 32'(out4_valid), 32'd0);

        // Simultaneous push/pop at full: only the pop happens
        out4_ready = 1'b0;
        for (int w = 0; w < 4; w++) begin
            in4 = 32'hA0 + 32'(w); in4_valid = 1'b1;
            step();
        end
        chk("full2_ready", 32'(in4_ready), 32'd0);
        in4 = 32'hAA; out4_ready = 1'b1;
        step();
        chk("pushpop_ready", 32'(in4_ready), 32'd1);
        chk("pushpop_head", out4, 32'hA1);
`ifdef OPAQUE_FIFO_COUNT_EN
        chk("pushpop_count", 32'(cnt4), 32'd3);
`endif

        // Reset mid-stream at occ=2 with a word offered
        in4_valid = 1'b0;
        step();
        chk("pre_rst_head", out4, 32'hA2);
        rst = 1'b1; in4 = 32'h55; in4_valid = 1'b1; out4_ready = 1'b0;
        step();
        rst = 1'b0; in4_valid = 1'b0;
        chk("rst_valid", 32'(out4_valid), 32'd0);
        chk("rst_ready", 32'(in4_ready), 32'd1);
`ifdef OPAQUE_FIFO_COUNT_EN
        chk("rst_count", 32'(cnt4), 32'd0);
`endif
        step();
        chk("rst_not_stored", 32'(out4_valid), 32'd0);

        // Randomized streaming through the depth-3 instance
        seq3 = 0;
        for (int cyc = 0; cyc < 30000 && rx3 < 1000; cyc++) begin
            in3        = 32'(seq3);
            in3_valid  = (seq3 < 1000) && ($urandom_range(0, 1) == 1);
            out3_ready = ($urandom_range(0, 1) == 1);
            accepted   = in3_valid && in3_ready;
            step();
            if (accepted) seq3++;
        end
        in3_valid = 1'b0;
        out3_ready = 1'b0;
        chk("rand_words_out", 32'(rx3), 32'd1000);
        chk("rand_words_in", 32'(seq3), 32'd1000);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
